fpu_issue_sched: RTL and testbench
==================================

Name: fpu_issue_sched

Overview:
- Issue scheduler for the shared multi-cycle FPU datapath in the core's execute stage.
- Accepts one FP operation per cycle from decode via valid/ready.
- Reserves the single FP writeback port at a fixed per-op latency and blocks the non-pipelined divide/sqrt unit while it is busy.
- Emits an issue pulse to the FPU and a tagged writeback strobe to the register-file write arbiter.

Parameters:
TAGW, 5, width of destination-register tag
LAT_ADD, 3, latency of ADD/SUB (pipelined)
LAT_MUL, 2, latency of MUL (pipelined)
LAT_DIV, 10, latency of DIV/SQRT (non-pipelined, shared unit)
LAT_MISC, 1, latency of CVT/CMP/SGNJ/reserved (pipelined)
MAXLAT, 16, depth of reservation vector; every LAT_* must be 1..MAXLAT

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  decode presents an FP op
req_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SQRT, 5 CVT, 6 CMP, 7 reserved (MISC class)
req_tag  in  TAGW  destination register tag
req_ready  out  1  scheduler can accept this cycle
flush  in  1  discard all in-flight ops (branch mispredict)
issue_valid  out  1  start pulse to FPU, = req_valid & req_ready
issue_op  out  3  op to FPU, = req_op
wb_valid  out  1  FP result writeback this cycle
wb_tag  out  TAGW  tag of writing-back op
div_busy  out  1  DIV/SQRT unit occupied
pending  out  5  count of accepted, not yet written-back ops

Behaviour:
- Reset (one cycle, synchronous): reservation vector cleared, tag slots cleared, div_busy=0, pending=0, wb_valid=0, wb_tag=0.
- req_ready is high in the first cycle after rst deasserts if no flush is present.
- Acceptance cycle T: the cycle where req_valid & req_ready is sampled at the rising edge.
- Op class latency L: ADD/SUB=LAT_ADD, MUL=LAT_MUL, DIV/SQRT=LAT_DIV, others=LAT_MISC.
- Writeback timing: wb_valid=1 for exactly one cycle, cycle T+L, with wb_tag = req_tag captured at T.
- Reservation vector res[1..MAXLAT]: res[k]=1 means writeback occurs k cycles from the current cycle. It shifts by one every cycle, and wb_valid is driven from the slot reaching 0.
- req_ready = !rst & !flush & !res[L(req_op)] & !(req_op is DIV/SQRT & div_busy).
- req_ready combinationally depends on req_op; decode must hold req_op stable while req_valid is high.
- The check uses the current-cycle vector, so a new op never writes back in the same cycle as an older op. No writeback collisions are possible.
- Pipelined classes accept back-to-back every cycle when there are no collisions.
- div_busy:
  - set in the cycle after a DIV/SQRT is accepted;
  - cleared in its writeback cycle, so a new DIV/SQRT may be accepted in that writeback cycle (subject to the res check).
- pending: +1 on accept, -1 on wb_valid, unchanged when both happen in the same cycle. Saturation cannot occur because pending is bounded by MAXLAT.
- flush cycle:
  - req_ready=0;
  - at the next edge the reservation vector, tags, div_busy and pending are cleared;
  - wb_valid=0 from the next cycle on.
- A wb_valid already high in the flush cycle still completes (the result is visible that cycle).
- Simultaneous flush and rst: rst dominates, with the same end state.
- rst mid-operation: all in-flight ops are dropped and no stale wb_valid appears afterward.

Test Plan:
1. ADD tag 5 accepted at T -> wb_valid=1, wb_tag=5 at T+3 only; pending 1 during T+1..T+3, 0 at T+4.
2. ADD tags 1,2,3 at T,T+1,T+2 -> req_ready stays 1; wb at T+3,T+4,T+5 with tags 1,2,3; issue_valid high T..T+2.
3. ADD at T, then MUL presented at T+1 -> req_ready=0 at T+1 (both would write back at T+3); MUL accepted T+2, wb T+4.
4. DIV tag 7 at T -> div_busy 1 T+1..T+9.
   - SQRT presented from T+1: ready=0 until T+10, accepted T+10, wb T+20.
   - ADD at T+1: accepted, wb T+4.
   - ADD at T+7: blocked (would write back at T+10).
5. ADD at T, MISC at T+1, flush at T+2 -> MISC wb at T+2 still seen; no wb at T+3; pending=0 at T+3; req_ready 0 at T+2, 1 at T+3.
6. DIV at T, rst at T+4 -> outputs zero at T+5; no wb at T+10; req_ready=1 and div_busy=0 at T+5.

Source files
------------

// File: rtl/fpu_issue_sched.sv
// rtl/fpu_issue_sched.sv - issue scheduler for the shared multi-cycle FPU with writeback-port reservation
module fpu_issue_sched #(
    parameter int TAGW     = 5,
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 10,
    parameter int LAT_MISC = 1,
    parameter int MAXLAT   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [TAGW-1:0] req_tag,
    output logic            req_ready,
    input  logic            flush,
    output logic            issue_valid,
    output logic [2:0]      issue_op,
    output logic            wb_valid,
    output logic [TAGW-1:0] wb_tag,
    output logic            div_busy,
    output logic [4:0]      pending
);
    localparam int CW = $clog2(MAXLAT + 1);

    // res[k] set: some accepted op writes back k cycles from now
    logic [MAXLAT:1]        res;
    logic [MAXLAT:1]        lat_mask;
    logic [MAXLAT*TAGW-1:0] tag_q;
    logic [MAXLAT*TAGW-1:0] tag_d;
    logic [CW-1:0]          div_cnt;
    int                     lat;
    logic                   is_div;
    logic                   accept;

    always_comb begin
        lat = LAT_MISC;
        case (req_op)
            3'd0, 3'd1: lat = LAT_ADD;
            3'd2:       lat = LAT_MUL;
            3'd3, 3'd4: lat = LAT_DIV;
            default:    lat = LAT_MISC;
        endcase
    end

    assign is_div = (req_op == 3'd3) || (req_op == 3'd4);

    genvar g;
    generate
        for (g = 1; g <= MAXLAT; g++) begin : g_mask
            assign lat_mask[g] = (lat == g);
        end
        // Tag slot k-1 next cycle comes from slot k, or from the new op if it lands there
        for (g = 1; g < MAXLAT; g++) begin : g_tag
            assign tag_d[(g-1)*TAGW +: TAGW] = (accept && lat_mask[g+1]) ? req_tag
                                                                         : tag_q[g*TAGW +: TAGW];
        end
    endgenerate
    assign tag_d[(MAXLAT-1)*TAGW +: TAGW] = '0;

    assign div_busy    = (div_cnt != '0);
    assign req_ready   = !rst && !flush && !(|(res & lat_mask)) && !(is_div && div_busy);
    assign accept      = req_valid && req_ready;
    assign issue_valid = accept;
    assign issue_op    = req_op;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            res      <= '0;
            tag_q    <= '0;
            wb_valid <= 1'b0;
            wb_tag   <= '0;
            div_cnt  <= '0;
            pending  <= '0;
        end else begin
            res      <= (res >> 1) | ({MAXLAT{accept}} & (lat_mask >> 1));
            tag_q    <= tag_d;
            wb_valid <= res[1] | (accept & lat_mask[1]);
            wb_tag   <= res[1] ? tag_q[TAGW-1:0]
                      : (accept && lat_mask[1]) ? req_tag : '0;
            // Busy through the cycle before the divide's writeback, free on the writeback cycle
            if (accept && is_div)
                div_cnt <= CW'(LAT_DIV - 1);
            else if (div_cnt != '0)
                div_cnt <= div_cnt - CW'(1);
            case ({accept, wb_valid})
                2'b10:   pending <= pending + 5'd1;
                2'b01:   pending <= pending - 5'd1;
                default: pending <= pending;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb/tb_fpu_issue_sched.sv - directed self-checking bench for fpu_issue_sched
module tb_fpu_issue_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = 3'd0;
    logic [4:0] req_tag = 5'd0;
    logic       req_ready;
    logic       flush = 1'b0;
    logic       issue_valid;
    logic [2:0] issue_op;
    logic       wb_valid;
    logic [4:0] wb_tag;
    logic       div_busy;
    logic [4:0] pending;

    int checks = 0;
    int errors = 0;

    fpu_issue_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_tag(req_tag),
        .req_ready(req_ready), .flush(flush), .issue_valid(issue_valid), .issue_op(issue_op),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .div_busy(div_busy), .pending(pending)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the edge, return at the falling edge for sampling
    task automatic cyc(input logic v, input logic [2:0] op, input logic [4:0] tag,
                       input logic fl, input logic r);
        @(posedge clk);
        #1;
        req_valid = v; req_op = op; req_tag = tag; flush = fl; rst = r;
        #4;
    endtask

    task automatic test_reset;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", req_ready); end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (wb_valid !== 1'b0 || wb_tag !== 5'd0) begin
            errors++; $display("FAIL rst_wb got %0b/%0d exp 0/0", wb_valid, wb_tag);
        end
        checks++;
        if (div_busy !== 1'b0 || pending !== 5'd0) begin
            errors++; $display("FAIL rst_state busy %0b pend %0d exp 0/0", div_busy, pending);
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b exp 1", req_ready); end
    endtask

    task automatic test_single_add;
        cyc(1, 3'd0, 5'd5, 0, 0);
        checks++;
        if (req_ready !== 1'b1 || issue_valid !== 1'b1 || issue_op !== 3'd0) begin
            errors++; $display("FAIL add_accept ready %0b issue %0b op %0d exp 1/1/0", req_ready, issue_valid, issue_op);
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 3'd0, 5'd0, 0, 0);
            checks++;
            if (wb_valid !== (i == 3)) begin
                errors++; $display("FAIL add_wb cyc %0d got %0b exp %0b", i, wb_valid, (i == 3));
            end
            if (i == 3) begin
                checks++;
                if (wb_tag !== 5'd5) begin errors++; $display("FAIL add_tag got %0d exp 5", wb_tag); end
            end
            checks++;
            if (pending !== ((i <= 3) ? 5'd1 : 5'd0)) begin
                errors++; $display("FAIL add_pending cyc %0d got %0d exp %0d", i, pending, (i <= 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) cyc(1, 3'd1, 5'(i + 1), 0, 0);
            else       cyc(0, 3'd0, 5'd0, 0, 0);
            checks++;
            if (issue_valid !== (i < 3)) begin
                errors++; $display("FAIL b2b_issue cyc %0d got %0b exp %0b", i, issue_valid, (i < 3));
            end
            checks++;
            if (wb_valid !== (i >= 3 && i <= 5)) begin
                errors++; $display("FAIL b2b_wb cyc %0d got %0b exp %0b", i, wb_valid, (i >= 3 && i <= 5));
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (wb_tag !== 5'(i - 2)) begin
                    errors++; $display("FAIL b2b_tag cyc %0d got %0d exp %0d", i, wb_tag, i - 2);
                end
            end
        end
    endtask

    task automatic test_collision;
        cyc(1, 3'd0, 5'd4, 0, 0);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL col_add_ready got %0b exp 1", req_ready); end
        cyc(1, 3'd2, 5'd6, 0, 0);
        checks++;
        if (req_ready !== 1'b0 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL col_mul_block ready %0b issue %0b exp 0/0", req_ready, issue_valid);
        end
        cyc(1, 3'd2, 5'd6, 0, 0);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL col_mul_accept got %0b exp 1", req_ready); end
        cyc(0, 3'd0, 5'd0, 0, 0);
        checks++;
        if (wb_valid !== 1'b1 || wb_tag !== 5'd4) begin
            errors++; $display("FAIL col_wb_add got %0b/%0d exp 1/4", wb_valid, wb_tag);
        end
        cyc(0, 3'd0, 5'd0, 0, 0);
        checks++;
        if (wb_valid !== 1'b1 || wb_tag !== 5'd6) begin
            errors++; $display("FAIL col_wb_mul got %0b/%0d exp 1/6", wb_valid, wb_tag);
        end
        cyc(0, 3'd0, 5'd0, 0, 0);
        checks++;
        if (wb_valid !== 1'b0 || pending !== 5'd0) begin
            errors++; $display("FAIL col_idle wb %0b pend %0d exp 0/0", wb_valid, pending);
        end
    endtask

    task automatic test_div;
        logic       v;
        logic [2:0] op;
        logic [4:0] tg;
        logic [4:0] exp_pend;
        logic       exp_wb;
        logic [4:0] exp_tag;
        for (int i = 0; i <= 21; i++) begin
            v = 1'b1; op = 3'd4; tg = 5'd9;
            if (i == 0)      begin op = 3'd3; tg = 5'd7; end
            else if (i == 1) begin op = 3'd0; tg = 5'd8; end
            else if (i == 7) begin op = 3'd0; tg = 5'd10; end
            else if (i > 10) begin v = 1'b0; op = 3'd0; tg = 5'd0; end
            cyc(v, op, tg, 0, 0);
            if (v) begin
                checks++;
                if (req_ready !== (i <= 1 || i == 10)) begin
                    errors++; $display("FAIL div_ready cyc %0d got %0b exp %0b", i, req_ready, (i <= 1 || i == 10));
                end
            end
            checks++;
            if (div_busy !== ((i >= 1 && i <= 9) || (i >= 11 && i <= 19))) begin
                errors++; $display("FAIL div_busy cyc %0d got %0b", i, div_busy);
            end
            exp_wb  = (i == 4 || i == 10 || i == 20);
            exp_tag = (i == 4) ? 5'd8 : (i == 10) ? 5'd7 : 5'd9;
            checks++;
            if (wb_valid !== exp_wb || (exp_wb && wb_tag !== exp_tag)) begin
                errors++; $display("FAIL div_wb cyc %0d got %0b/%0d exp %0b/%0d", i, wb_valid, wb_tag, exp_wb, exp_tag);
            end
            exp_pend = (i == 0) ? 5'd0 : (i == 1) ? 5'd1 : (i <= 4) ? 5'd2 : (i <= 20) ? 5'd1 : 5'd0;
            checks++;
            if (pending !== exp_pend) begin
                errors++; $display("FAIL div_pending cyc %0d got %0d exp %0d", i, pending, exp_pend);
            end
        end
    endtask

    task automatic test_flush;
        cyc(1, 3'd0, 5'd11, 0, 0);
        cyc(1, 3'd5, 5'd12, 0, 0);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_misc_ready got %0b exp 1", req_ready); end
        cyc(1, 3'd0, 5'd13, 1, 0);
        checks++;
        if (req_ready !== 1'b0 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL flush_ready ready %0b issue %0b exp 0/0", req_ready, issue_valid);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_tag !== 5'd12) begin
            errors++; $display("FAIL flush_wb_inflight got %0b/%0d exp 1/12", wb_valid, wb_tag);
        end
        cyc(0, 3'd0, 5'd0, 0, 0);
        checks++;
        if (req_ready !== 1'b1 || pending !== 5'd0) begin
            errors++; $display("FAIL flush_after ready %0b pend %0d exp 1/0", req_ready, pending);
        end
        for (int i = 3; i <= 6; i++) begin
            if (i > 3) cyc(0, 3'd0, 5'd0, 0, 0);
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_wb cyc %0d got %0b exp 0", i, wb_valid); end
        end
    endtask

    task automatic test_reset_mid;
        cyc(1, 3'd3, 5'd14, 0, 0);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_div_ready got %0b exp 1", req_ready); end
        for (int i = 1; i <= 3; i++) cyc(0, 3'd0, 5'd0, 0, 0);
        checks++;
        if (div_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %0b exp 1", div_busy); end
        cyc(0, 3'd0, 5'd0, 1, 1);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst got %0b exp 0", req_ready); end
        cyc(0, 3'd3, 5'd0, 0, 0);
        checks++;
        if (req_ready !== 1'b1 || div_busy !== 1'b0 || pending !== 5'd0 || wb_valid !== 1'b0 || wb_tag !== 5'd0) begin
            errors++; $display("FAIL rstmid_clear ready %0b busy %0b pend %0d wb %0b tag %0d exp 1/0/0/0/0",
                               req_ready, div_busy, pending, wb_valid, wb_tag);
        end
        for (int i = 6; i <= 12; i++) begin
            cyc(0, 3'd0, 5'd0, 0, 0);
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_wb cyc %0d got %0b exp 0", i, wb_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_back_to_back;
        test_collision;
        test_div;
        test_flush;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
